// File: rtl/gold_pkg.sv
// Shared constants, the correlator width helper and the lock state type.
package gold_pkg;

   localparam int unsigned CODE_LEN_DEF = 31;

   // Enough bits to hold a match count from 0 to len inclusive.
   function automatic int unsigned corr_w(input int unsigned len);
      return $clog2(len + 1);
   endfunction

   typedef enum logic {
      SEARCH,
      LOCK
   } state_e;

endpackage

// File: rtl/gold_corr_if.sv
// Chip stream in, correlation/lock/data results out.
interface gold_corr_if
   import gold_pkg::*;
#(
   parameter int unsigned CODE_LEN = CODE_LEN_DEF
);

   localparam int unsigned CORR_W = corr_w(CODE_LEN);

   logic                chip_i;
   logic                strobe_i;
   logic                ref_load_i;
   logic [CODE_LEN-1:0] ref_code_i;
   logic [CORR_W-1:0]   corr_o;
   logic                corr_valid_o;
   logic                lock_o;
   logic                data_bit_o;
   logic                data_valid_o;

   // Chip source / reference loader side.
   modport master (
      output chip_i, strobe_i, ref_load_i, ref_code_i,
      input  corr_o, corr_valid_o, lock_o, data_bit_o, data_valid_o
   );

   // Correlator side.
   modport slave (
      input  chip_i, strobe_i, ref_load_i, ref_code_i,
      output corr_o, corr_valid_o, lock_o, data_bit_o, data_valid_o
   );

endinterface

// File: rtl/gold_popcount.sv
// Combinational population count over a WIDTH-bit vector.
module gold_popcount #(
   parameter int unsigned WIDTH = 31
) (
   input  logic [WIDTH-1:0]           data_i,
   output logic [$clog2(WIDTH+1)-1:0] count_o
);

   localparam int unsigned OUT_W = $clog2(WIDTH + 1);

   // Sum every set bit.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         count_o = count_o + OUT_W'(data_i[i]);
      end
   end

endmodule

// File: rtl/gold_corr.sv
// Sliding-window Gold code correlator with epoch-tracked lock and despreading.
module gold_corr
   import gold_pkg::*;
#(
   parameter int unsigned CODE_LEN = CODE_LEN_DEF,
   parameter int unsigned THRESH   = 28,
   parameter int unsigned MISS_MAX = 3
) (
   input logic        clkin,
   input logic        rst,
   gold_corr_if.slave bus
);

   localparam int unsigned CORR_W = corr_w(CODE_LEN);
   localparam int unsigned PH_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam int unsigned MISS_W = (MISS_MAX > 1) ? $clog2(MISS_MAX + 1) : 1;

   localparam logic [CORR_W-1:0] FILL_FULL = CORR_W'(CODE_LEN);
   localparam logic [CORR_W-1:0] THR_HI    = CORR_W'(THRESH);
   localparam logic [CORR_W-1:0] THR_LO    = CORR_W'(CODE_LEN - THRESH);
   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CODE_LEN - 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

   logic [CODE_LEN-1:0] hist_q;
   logic [CODE_LEN-1:0] ref_q;
   logic [CORR_W-1:0]   fill_q;
   logic                shifted_q;
   logic [CORR_W-1:0]   match_cnt;
   logic [CORR_W-1:0]   corr_q;
   logic                corr_valid_q;

   state_e              state_q, state_d;
   logic [PH_W-1:0]     phase_q, phase_d;
   logic [MISS_W-1:0]   miss_q, miss_d;
   logic                data_bit_q, data_bit_d;
   logic                data_valid_q, data_valid_d;

   logic                peak_hi, peak_lo;

   gold_popcount #(
      .WIDTH (CODE_LEN)
   ) u_popcount (
      .data_i  (~(hist_q ^ ref_q)),
      .count_o (match_cnt)
   );

   // Chip history, reference and fill tracking; a load discards any coincident chip.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         hist_q    <= '0;
         ref_q     <= '0;
         fill_q    <= '0;
         shifted_q <= 1'b0;
      end else if (bus.ref_load_i) begin
         ref_q     <= bus.ref_code_i;
         hist_q    <= '0;
         fill_q    <= '0;
         shifted_q <= 1'b0;
      end else begin
         shifted_q <= bus.strobe_i;
         if (bus.strobe_i) begin
            hist_q <= {hist_q[CODE_LEN-2:0], bus.chip_i};
            if (fill_q != FILL_FULL) begin
               fill_q <= fill_q + CORR_W'(1);
            end
         end
      end
   end

   // Register the correlation one cycle after the chip lands in the history.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         corr_q       <= '0;
         corr_valid_q <= 1'b0;
      end else begin
         corr_valid_q <= shifted_q && (fill_q == FILL_FULL) && !bus.ref_load_i;
         if (shifted_q) begin
            corr_q <= match_cnt;
         end
      end
   end

   assign peak_hi = (corr_q >= THR_HI);
   assign peak_lo = (corr_q <= THR_LO);

   // Lock state, epoch phase, miss count and despread output registers.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         state_q      <= SEARCH;
         phase_q      <= '0;
         miss_q       <= '0;
         data_bit_q   <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         miss_q       <= miss_d;
         data_bit_q   <= data_bit_d;
         data_valid_q <= data_valid_d;
      end
   end

   // Acquire on any peak; once locked only the epoch correlation counts.
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      miss_d       = miss_q;
      data_bit_d   = data_bit_q;
      data_valid_d = 1'b0;
      if (bus.ref_load_i) begin
         state_d = SEARCH;
         phase_d = '0;
         miss_d  = '0;
      end else if (corr_valid_q) begin
         case (state_q)
            SEARCH: begin
               if (peak_hi || peak_lo) begin
                  state_d      = LOCK;
                  phase_d      = '0;
                  miss_d       = '0;
                  data_bit_d   = peak_hi;
                  data_valid_d = 1'b1;
               end
            end
            LOCK: begin
               if (phase_q == PH_LAST) begin
                  phase_d = '0;
                  if (peak_hi || peak_lo) begin
                     miss_d       = '0;
                     data_bit_d   = peak_hi;
                     data_valid_d = 1'b1;
                  end else if (miss_q == MISS_LAST) begin
                     state_d = SEARCH;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_q + MISS_W'(1);
                  end
               end else begin
                  phase_d = phase_q + PH_W'(1);
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   assign bus.corr_o       = corr_q;
   assign bus.corr_valid_o = corr_valid_q;
   assign bus.lock_o       = (state_q == LOCK);
   assign bus.data_bit_o   = data_bit_q;
   assign bus.data_valid_o = data_valid_q;

endmodule
